vec_stream_tx: RTL and testbench

- Read-side counterpart to the processor's vector writes.
- After the processor has written FIR output lines through the 128-bit vector port of the data RAM, this block reads them back through that port, one 128-bit line at a time.
- Each line is unpacked into 16 bytes, and every byte is sent out of the FPGA as a UART 8N1 frame, so the filtered audio can be captured on a host.
- It is the only reader on the vector port while busy; the processor must not issue vector writes during a transfer.

---
 rtl/vec_stream_tx_pkg.sv | 23 ++
 rtl/vec_stream_tx_if.sv | 25 ++
 rtl/vec_stream_tx_uart.sv | 72 +++++++
 rtl/vec_stream_tx.sv | 129 ++++++++++++
 tb/tb_vec_stream_tx.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_stream_tx_pkg.sv
// Shared constants for the vector-line UART streamer: FSM encoding,
// line/byte geometry helper and UART frame constants.
package vec_stream_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;
  localparam logic [2:0] S_NEXTB = 3'd5;
  localparam logic [2:0] S_NEXTL = 3'd6;
  localparam logic [2:0] S_FIN   = 3'd7;

  // 8N1: start + 8 data + stop
  localparam int FRAME_BITS = 10;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] STOP_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  function automatic int bytes_per_line(input int line_w);
    return line_w / 8;
  endfunction

endpackage

// File: rtl/vec_stream_tx_if.sv
// Command, vector-port and serial-output bundle of vec_stream_tx.
interface vec_stream_tx_if #(
  parameter int ADDR_W = 15,
  parameter int LINE_W = 128
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_lines;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rden;
  logic [LINE_W-1:0] mem_q;
  logic              tx;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, num_lines, mem_q,
    output mem_addr, mem_rden, tx, busy, done
  );

  modport master (
    output start, base_addr, num_lines, mem_q,
    input  mem_addr, mem_rden, tx, busy, done
  );
endinterface

// File: rtl/vec_stream_tx_uart.sv
// UART 8N1 serializer: one frame per load pulse, frame_done_o asserted
// combinationally in the last cycle of the stop bit.
module uart_tx_core
  import vec_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_i,
  input  logic       load_i,
  output logic       tx_o,
  output logic       frame_done_o
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  logic [BW-1:0]         baud_q, baud_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  active_q, active_d;
  logic                  tx_q, tx_d;

  assign tx_o         = tx_q;
  assign frame_done_o = active_q && (baud_q == BAUD_MAX) && (bit_q == STOP_BIT);

  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    active_d = active_q;
    tx_d     = tx_q;
    if (load_i && !active_q) begin
      frame_d  = {1'b1, byte_i, 1'b0};
      active_d = 1'b1;
      bit_d    = '0;
      baud_d   = '0;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (baud_q == BAUD_MAX) begin
        baud_d = '0;
        if (bit_q == STOP_BIT) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          // frame_q[0] is the bit on the line; shift the next one down
          bit_d   = bit_q + 1'b1;
          frame_d = {1'b1, frame_q[FRAME_BITS-1:1]};
          tx_d    = frame_q[1];
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_q   <= '0;
      bit_q    <= '0;
      frame_q  <= '1;
      active_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      active_q <= active_d;
      tx_q     <= tx_d;
    end
  end
endmodule

// File: rtl/vec_stream_tx.sv
// Reads vector lines back from the data RAM and streams every byte,
// LSB byte first, out of a UART 8N1 serializer.
module vec_stream_tx
  import vec_stream_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int LINE_W       = 128,
  parameter int CLKS_PER_BIT = 434,
  parameter int RD_LAT       = 2
) (
  input logic           clk,
  input logic           reset,
  vec_stream_tx_if.slave bus
);
  localparam int BPL = bytes_per_line(LINE_W);
  localparam int BIW = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int WW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [BIW-1:0] BIDX_MAX = BIW'(BPL - 1);
  localparam logic [WW-1:0]  WAIT_MAX = WW'(RD_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] lines_q, lines_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [BIW-1:0]    bidx_q, bidx_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              sent_q, sent_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load;
  logic              frame_done;
  logic [7:0]        cur_byte;

  assign cur_byte     = line_q[{bidx_q, 3'b000} +: 8];
  assign bus.mem_addr = addr_q;
  assign bus.mem_rden = (state_q == S_RD);
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lines_d = lines_q;
    line_d  = line_q;
    bidx_d  = bidx_q;
    wait_d  = wait_q;
    sent_d  = sent_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        addr_d  = bus.base_addr;
        lines_d = bus.num_lines;
        busy_d  = 1'b1;
        state_d = (bus.num_lines == '0) ? S_FIN : S_RD;
      end
      S_RD: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (wait_q == WAIT_MAX) state_d = S_LOAD;
              else wait_d = wait_q + 1'b1;
      S_LOAD: begin
        line_d  = bus.mem_q;
        bidx_d  = '0;
        sent_d  = 1'b0;
        state_d = S_SEND;
      end
      // one load per byte, then hold until the serializer finishes the stop bit
      S_SEND: if (!sent_q) begin
        load   = 1'b1;
        sent_d = 1'b1;
      end else if (frame_done) begin
        sent_d  = 1'b0;
        state_d = S_NEXTB;
      end
      S_NEXTB: if (bidx_q == BIDX_MAX) state_d = S_NEXTL;
               else begin
                 bidx_d  = bidx_q + 1'b1;
                 state_d = S_SEND;
               end
      S_NEXTL: begin
        addr_d  = addr_q + 1'b1;
        lines_d = lines_q - 1'b1;
        state_d = (lines_q == ADDR_W'(1)) ? S_FIN : S_RD;
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lines_q <= '0;
      line_q  <= '0;
      bidx_q  <= '0;
      wait_q  <= '0;
      sent_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lines_q <= lines_d;
      line_q  <= line_d;
      bidx_q  <= bidx_d;
      wait_q  <= wait_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk          (clk),
    .reset        (reset),
    .byte_i       (cur_byte),
    .load_i       (load),
    .tx_o         (bus.tx),
    .frame_done_o (frame_done)
  );
endmodule

// File: tb/tb_vec_stream_tx.sv
// Randomized bench for vec_stream_tx: RAM model, UART frame decoder and
// a line/byte reference queue built from the RAM contents.
module tb_vec_stream_tx;
  localparam int ADDR_W    = 15;
  localparam int LINE_W    = 128;
  localparam int CPB       = 4;
  localparam int RD_LAT    = 2;
  localparam int BPL       = LINE_W / 8;
  localparam int FRAME_CYC = 10 * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vec_stream_tx_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  vec_stream_tx #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CLKS_PER_BIT(CPB), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM with registered address and registered output; data holds until next read
  logic [LINE_W-1:0] ram [logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] ram_s1;

  function automatic logic [LINE_W-1:0] ram_rd(input logic [ADDR_W-1:0] a);
    return ram.exists(a) ? ram[a] : '0;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rden) ram_s1 <= ram_rd(bus.mem_addr);
    bus.mem_q <= ram_s1;
  end

  // monitor: UART decoder plus event logs (only this process writes them)
  int cyc = 0, done_cnt = 0, tx_low = 0, shape_bad = 0, vio = 0;
  int mcnt = 0, last_end = 0, cur_gap = 0;
  logic mon_active = 1'b0;
  logic samp [FRAME_CYC];
  logic [ADDR_W-1:0] rd_log [$];
  logic [7:0] rx_q [$];
  int gap_q [$];

  initial begin
    logic ok;
    logic [7:0] rb;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.done) done_cnt++;
      if (bus.mem_rden) rd_log.push_back(bus.mem_addr);
      if (!bus.tx) tx_low++;
      if (!reset) mon_active = 1'b0;
      else if (!mon_active) begin
        if (!bus.tx) begin
          mon_active = 1'b1;
          samp[0] = 1'b0;
          mcnt = 1;
          cur_gap = cyc - last_end - 1;
        end
      end else begin
        samp[mcnt] = bus.tx;
        mcnt++;
        if (mcnt == FRAME_CYC) begin
          mon_active = 1'b0;
          last_end = cyc;
          ok = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int j = 0; j < CPB; j++)
              if (samp[b*CPB+j] !== samp[b*CPB]) ok = 1'b0;
          if (samp[0] !== 1'b0 || samp[9*CPB] !== 1'b1) ok = 1'b0;
          for (int k = 0; k < 8; k++) rb[k] = samp[(k+1)*CPB];
          if (!ok) shape_bad++;
          rx_q.push_back(rb);
          gap_q.push_back(cur_gap);
        end
      end
      if (mon_active && !bus.busy) vio++;
    end
  end

  // reference: the byte stream is just the addressed lines, low byte first
  logic [7:0] exp_bytes [$];
  logic [ADDR_W-1:0] exp_addrs [$];
  int rx0, rd0, dn0, sh0, vio0, txl0;

  task automatic build_exp(input int base, input int n);
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] ln;
    exp_bytes.delete();
    exp_addrs.delete();
    for (int i = 0; i < n; i++) begin
      a = ADDR_W'(base + i);
      exp_addrs.push_back(a);
      ln = ram_rd(a);
      for (int k = 0; k < BPL; k++) exp_bytes.push_back(ln[8*k +: 8]);
    end
  endtask

  task automatic fill_rand(input int base, input int n);
    for (int i = 0; i < n; i++)
      ram[ADDR_W'(base + i)] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic start_xfer(input int base, input int n);
    rx0 = rx_q.size(); rd0 = rd_log.size(); dn0 = done_cnt;
    sh0 = shape_bad; vio0 = vio; txl0 = tx_low;
    @(negedge clk); #1;
    bus.start = 1'b1;
    bus.base_addr = ADDR_W'(base);
    bus.num_lines = ADDR_W'(n);
    @(negedge clk); #1;
    bus.start = 1'b0;
    chk("busy_rise", bus.busy, 1);
  endtask

  task automatic wait_done(input int budget, input int glitch_at, input int glitch_base);
    int k = 0;
    while (done_cnt == dn0 && k < budget) begin
      if (glitch_at > 0 && k == glitch_at) begin
        bus.start = 1'b1;
        bus.base_addr = ADDR_W'(glitch_base);
        bus.num_lines = ADDR_W'(5);
      end else bus.start = 1'b0;
      @(negedge clk); #1;
      k++;
    end
    bus.start = 1'b0;
    chk("done_in_time", done_cnt != dn0, 1);
    repeat (20) @(negedge clk);
    #1;
  endtask

  task automatic check_xfer(input string name);
    int nb, na, maxgap;
    na = rd_log.size() - rd0;
    nb = rx_q.size() - rx0;
    chk({name, "_rd_cnt"}, na, exp_addrs.size());
    for (int i = 0; i < na && i < exp_addrs.size(); i++)
      chk({name, "_rd_addr"}, rd_log[rd0+i], exp_addrs[i]);
    chk({name, "_byte_cnt"}, nb, exp_bytes.size());
    for (int i = 0; i < nb && i < exp_bytes.size(); i++)
      chk({name, "_byte"}, rx_q[rx0+i], exp_bytes[i]);
    chk({name, "_done_cnt"}, done_cnt - dn0, 1);
    chk({name, "_frame_shape"}, shape_bad - sh0, 0);
    chk({name, "_busy_span"}, vio - vio0, 0);
    chk({name, "_busy_end"}, bus.busy, 0);
    maxgap = 0;
    for (int i = 1; i < nb; i++)
      if (i % BPL != 0 && gap_q[rx0+i] > maxgap) maxgap = gap_q[rx0+i];
    chk({name, "_gap_le3"}, maxgap <= 3, 1);
  endtask

  function automatic int budget_for(input int n);
    return n * BPL * (FRAME_CYC + 6) + 100;
  endfunction

  initial begin
    logic [LINE_W-1:0] ln;
    int b, n;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.num_lines = '0;

    // reset idle with start toggling
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.start = ~bus.start;
      bus.num_lines = ADDR_W'(1);
      @(negedge clk); #1;
      chk("rst_idle", {bus.tx, bus.busy, bus.done, bus.mem_rden}, 4'b1000);
    end
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single line with ascending bytes
    for (int k = 0; k < BPL; k++) ln[8*k +: 8] = 8'(k);
    ram[ADDR_W'(3)] = ln;
    build_exp(3, 1);
    start_xfer(3, 1);
    wait_done(budget_for(1), 0, 0);
    check_xfer("single");

    // two lines wrapping past the top of the address space
    fill_rand(32'h7FFF, 2);
    build_exp(32'h7FFF, 2);
    start_xfer(32'h7FFF, 2);
    wait_done(budget_for(2), 0, 0);
    check_xfer("wrap");

    // zero length
    rx0 = rx_q.size(); rd0 = rd_log.size(); dn0 = done_cnt; txl0 = tx_low;
    @(negedge clk); #1;
    bus.start = 1'b1; bus.base_addr = ADDR_W'(9); bus.num_lines = '0;
    @(negedge clk); #1;
    bus.start = 1'b0;
    chk("zero_c1", {bus.busy, bus.done}, 2'b10);
    @(negedge clk); #1;
    chk("zero_c2", {bus.busy, bus.done}, 2'b01);
    @(negedge clk); #1;
    chk("zero_c3", {bus.busy, bus.done}, 2'b00);
    repeat (10) @(negedge clk);
    #1;
    chk("zero_rd", rd_log.size() - rd0, 0);
    chk("zero_txlow", tx_low - txl0, 0);
    chk("zero_done_cnt", done_cnt - dn0, 1);

    // start while busy is ignored
    b = $urandom_range(0, 32'h7FFF);
    fill_rand(b, 3);
    fill_rand(b + 100, 5);
    build_exp(b, 3);
    start_xfer(b, 3);
    wait_done(budget_for(3), 60, b + 100);
    check_xfer("busy_start");

    // randomized transfers
    for (int t = 0; t < 2; t++) begin
      b = $urandom_range(0, 32'h7FFF);
      n = $urandom_range(1, 3);
      fill_rand(b, n);
      build_exp(b, n);
      start_xfer(b, n);
      wait_done(budget_for(n), 0, 0);
      check_xfer("rand");
    end

    // reset during data bit 4 of byte 5
    fill_rand(32'h100, 1);
    build_exp(32'h100, 1);
    start_xfer(32'h100, 1);
    begin
      int k = 0;
      while (!(rx_q.size() - rx0 == 5 && mon_active && mcnt == 5*CPB + 2) && k < budget_for(1)) begin
        @(negedge clk); #1;
        k++;
      end
      chk("rst_reach_bit4", k < budget_for(1), 1);
    end
    chk("pre_rst_bit", bus.tx, exp_bytes[5][4]);
    reset = 1'b0;
    #1;
    chk("rst_tx_async", bus.tx, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hold", {bus.tx, bus.busy, bus.done, bus.mem_rden}, 4'b1000);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_no_done", done_cnt - dn0, 0);
    chk("rst_idle_after", bus.busy, 0);

    fill_rand(32'h2A0, 2);
    build_exp(32'h2A0, 2);
    start_xfer(32'h2A0, 2);
    wait_done(budget_for(2), 0, 0);
    check_xfer("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
